spi_rom_responder: RTL and testbench
====================================

SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, number of flip-flops in the SCLK/CSn/MOSI input synchronisers (legal values 2-3).
REQ-002 The block SHALL have a port wb_clk_i, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have a port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have a port spi_csn, input, 1 bit: chip select, active low, asynchronous to wb_clk_i.
REQ-005 The block SHALL have a port spi_sclk, input, 1 bit: serial clock, SPI mode 0, asynchronous to wb_clk_i.
REQ-006 The block SHALL have a port spi_mosi, input, 1 bit: serial data from the initiator.
REQ-007 The block SHALL have a port spi_miso, output, 1 bit: serial data to the initiator.
REQ-008 The block SHALL have a port spi_miso_oe, output, 1 bit: MISO pad output enable.
REQ-009 The block SHALL have a port mem_addr, output, 24 bits: byte address of the memory read.
REQ-010 The block SHALL have a port mem_req, output, 1 bit: memory read request, held high until acknowledged.
REQ-011 The block SHALL have a port mem_ack, input, 1 bit: one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-012 The block SHALL have a port mem_rdata, input, 8 bits: memory read data.
REQ-013 The block SHALL have a port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have a port underrun, output, 1 bit: sticky flag, set when a byte was needed before mem_ack arrived.

Function
REQ-015 spi_sclk, spi_csn and spi_mosi SHALL each pass through SYNC_STAGES flip-flops; SCLK rising and falling edges SHALL be detected from the last two synchronised samples.
REQ-016 Supported SCLK frequency SHALL be at most wb_clk_i/8.
REQ-017 The states SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-018 From any state, a synchronised spi_csn of 1 SHALL force IDLE on the next cycle, abort the current transaction and drop mem_req; an outstanding ack is discarded.
REQ-019 On a synchronised spi_csn of 0 in IDLE, the block SHALL enter CMD with the bit counter cleared.
REQ-020 MOSI SHALL be sampled on each SCLK rising edge, MSB first; 8 bits form the command byte.
REQ-021 Command 0x03 SHALL go to ADDR; any other command (and 0x0B when REQ-030 is disabled) SHALL go to IGNORE, which holds until spi_csn rises.
REQ-022 ADDR SHALL shift in 24 bits, MSB first, into the address register.
REQ-023 In the wb_clk_i cycle after the 24th address bit is sampled, the block SHALL assert mem_req with mem_addr equal to the received address, then enter DATA.
REQ-024 On mem_ack, the block SHALL capture mem_rdata into a prefetch buffer, deassert mem_req and increment the address, wrapping 0xFFFFFF to 0x000000.
REQ-025 In DATA, on each SCLK falling edge, the block SHALL drive the next MISO bit MSB first; at bit 0 of each byte it SHALL move the prefetch buffer into the shift register and immediately request the next byte.
REQ-026 If the prefetch buffer is empty at a byte load, the block SHALL shift out 0xFF and set underrun, while the address still advances by one.
REQ-027 spi_miso_oe SHALL be 1 only in DATA while spi_csn is low; spi_miso SHALL be 1 whenever spi_miso_oe is 0.
REQ-028 mem_req SHALL never be high in IDLE, CMD or IGNORE.

Reset
REQ-029 On wb_rst_i, the state SHALL be IDLE and the outputs SHALL reset as follows: spi_miso=1, spi_miso_oe=0, mem_req=0, mem_addr=0, busy=0, underrun=0; the synchronisers SHALL be preset to csn=1, sclk=0; the prefetch buffer SHALL be empty. Reset is the only way to clear underrun.

Configuration
REQ-030 When SPI_FAST_READ_EN is defined, command 0x0B SHALL take the path ADDR -> DUMMY (8 SCLK cycles, MOSI ignored, MISO disabled) -> DATA, with mem_req issued on entry to DUMMY; when it is undefined, 0x0B SHALL go to IGNORE and the DUMMY state SHALL not exist.

Verification
REQ-031 The bench SHALL cover a normal read: wb_clk 50 MHz, SCLK 5 MHz, 03 00 01 00, then 4 bytes with memory [0x100..0x103]=A5 5A C3 3C and ack after 2 cycles -> MISO returns A5 5A C3 3C and mem_addr steps 0x100..0x104.
REQ-032 The bench SHALL cover wrap-around: 03 FF FF FF, then 2 bytes -> mem_addr sequence FFFFFF, 000000 and data from both addresses.
REQ-033 The bench SHALL cover an abort: CSn raised after 12 address bits -> IDLE within SYNC_STAGES+2 cycles, mem_req never asserted; a following 03 00 00 10 read succeeds.
REQ-034 The bench SHALL cover an unknown command: 0x9F -> IGNORE, spi_miso_oe stays 0 and mem_req stays 0 until CSn rises.
REQ-035 The bench SHALL cover an underrun: mem_ack withheld -> the first byte reads FF, underrun=1 and stays 1 after CSn rises, cleared only by wb_rst_i.
REQ-036 The bench SHALL cover fast read: with SPI_FAST_READ_EN defined, 0B 00 00 20 + 8 dummy clocks -> byte at 0x20; without it -> IGNORE.

Source files
------------

// File: rtl/spi_rom_responder.sv
// SPI mode-0 ROM responder: serves READ (0x03) from a byte-wide memory port with a one-byte prefetch.
// Optional macro SPI_FAST_READ_EN adds FAST READ (0x0B) with 8 dummy clocks.
`timescale 1ns/1ps
module spi_rom_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR,
`ifdef SPI_FAST_READ_EN
        DUMMY,
`endif
        DATA, IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`endif

    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_vld_q, buf_vld_d;
    logic [7:0]  shift_q, shift_d;
    logic        miso_q, miso_d;
    logic        underrun_q, underrun_d;

    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            buf_vld_q  <= 1'b0;
            miso_q     <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            buf_vld_q  <= buf_vld_d;
            miso_q     <= miso_d;
            underrun_q <= underrun_d;
        end
    end

    // Payload registers carry no reset; buf_vld_q qualifies the buffer.
    always_ff @(posedge wb_clk_i) begin
        buf_q   <= buf_d;
        shift_q <= shift_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        req_d      = req_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        shift_d    = shift_q;
        miso_d     = miso_q;
        underrun_d = underrun_q;
        if (csn_s) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            buf_vld_d = 1'b0;
            miso_d    = 1'b1;
        end else begin
            if (req_q && mem_ack) begin
                buf_d     = mem_rdata;
                buf_vld_d = 1'b1;
                req_d     = 1'b0;
                addr_d    = addr_q + 24'd1;
            end
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (sclk_rise) begin
                    shift_d = {shift_q[6:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        if (shift_d == CMD_READ) state_d = ADDR;
`ifdef SPI_FAST_READ_EN
                        if (shift_d == CMD_FAST_READ) state_d = ADDR;
`endif
                    end
                end
                // shift_q still holds the command byte while the address shifts in.
                ADDR: if (sclk_rise) begin
                    addr_d = {addr_q[22:0], mosi_s};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        miso_d  = 1'b1;
                        state_d = DATA;
`ifdef SPI_FAST_READ_EN
                        if (shift_q == CMD_FAST_READ) state_d = DUMMY;
`endif
                    end
                end
`ifdef SPI_FAST_READ_EN
                DUMMY: if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
`endif
                DATA: if (sclk_fall) begin
                    cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                    if (cnt_q[2:0] == 3'd0) begin
                        req_d = 1'b1;
                        if (buf_vld_q) begin
                            shift_d   = {buf_q[6:0], 1'b1};
                            miso_d    = buf_q[7];
                            buf_vld_d = 1'b0;
                        end else if (req_q && mem_ack) begin
                            shift_d   = {mem_rdata[6:0], 1'b1};
                            miso_d    = mem_rdata[7];
                            buf_vld_d = 1'b0;
                        end else begin
                            // Byte slot is skipped: send all ones and move on to the next address.
                            shift_d    = 8'hFF;
                            miso_d     = 1'b1;
                            underrun_d = 1'b1;
                            addr_d     = addr_q + 24'd1;
                        end
                    end else begin
                        miso_d  = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b1};
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign spi_miso_oe = (state_q == DATA) && !csn_s;
    assign spi_miso    = spi_miso_oe ? miso_q : 1'b1;
    assign mem_addr    = addr_q;
    assign mem_req     = req_q;
    assign busy        = (state_q != IDLE);
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed and randomized transactions for spi_rom_responder against a byte-level read model.
`timescale 1ns/1ps
module tb_spi_rom_responder;

    localparam int SYNC = 2;
    localparam int HALF = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [23:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy, underrun;

    spi_rom_responder #(.SYNC_STAGES(SYNC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .underrun(underrun)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0]  mem [logic [23:0]];
    logic [23:0] ack_log [$];
    logic [7:0]  rxq [$];
    int log_base;
    int req_cnt = 0;
    int oe_cnt = 0;
    bit ack_en = 1'b1;
    int ack_dly = 2;
    int wcnt = 0;

    function automatic logic [7:0] memval(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Memory responder: one-cycle ack ack_dly cycles after the request is seen.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && ack_en) begin
            if (wcnt >= ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = memval(mem_addr);
                ack_log.push_back(mem_addr);
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req) req_cnt++;
        if (spi_miso_oe) oe_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        #5;
        spi_csn = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spi_csn = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int ndummy, input int n);
        logic [7:0] r;
        rxq.delete();
        log_base = ack_log.size();
        cs_low();
        spi_bits(cmd, 8, r);
        spi_bits(a[23:16], 8, r);
        spi_bits(a[15:8], 8, r);
        spi_bits(a[7:0], 8, r);
        for (int i = 0; i < ndummy; i++) spi_bits(8'($urandom), 8, r);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, r);
            rxq.push_back(r);
        end
    endtask

    // Reference: byte i comes from address a+i (24-bit wrap); requests step a, a+1, ... a+n.
    task automatic check_read(input string tag, input logic [23:0] a, input int n);
        logic [23:0] e;
        for (int i = 0; i < n; i++) begin
            e = a + 24'(i);
            check({tag, "_data"}, 32'(rxq[i]), 32'(memval(e)));
        end
        for (int i = 0; i <= n; i++) begin
            e = a + 24'(i);
            check({tag, "_addr"}, (ack_log.size() > log_base + i) ? 32'(ack_log[log_base + i]) : 32'hDEADBEEF, 32'(e));
        end
    endtask

    initial begin
        logic [23:0] a;
        logic [7:0]  r;
        int n, cycles, rq0, oe0;

        do_reset();
        check("rst_miso", 32'(spi_miso), 32'd1);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Normal read
        mem[24'h000100] = 8'hA5; mem[24'h000101] = 8'h5A;
        mem[24'h000102] = 8'hC3; mem[24'h000103] = 8'h3C;
        ack_dly = 2;
        do_read(8'h03, 24'h000100, 0, 4);
        check("normal_busy", 32'(busy), 32'd1);
        check("normal_oe", 32'(spi_miso_oe), 32'd1);
        cs_high();
        check_read("normal", 24'h000100, 4);
        check("normal_idle", 32'(busy), 32'd0);
        check("normal_req_idle", 32'(mem_req), 32'd0);
        check("normal_underrun", 32'(underrun), 32'd0);

        // Wrap-around
        mem[24'hFFFFFF] = 8'h81; mem[24'h000000] = 8'h7E;
        do_read(8'h03, 24'hFFFFFF, 0, 2);
        cs_high();
        check_read("wrap", 24'hFFFFFF, 2);

        // Abort mid-address
        rq0 = req_cnt;
        cs_low();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 4, r);
        spi_csn = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check("abort_latency_ok", 32'(cycles <= SYNC + 2), 32'd1);
        check("abort_no_req", 32'(req_cnt - rq0), 32'd0);
        repeat (4) @(negedge clk);
        mem[24'h000010] = 8'($urandom); mem[24'h000011] = 8'($urandom);
        do_read(8'h03, 24'h000010, 0, 2);
        cs_high();
        check_read("post_abort", 24'h000010, 2);

        // Unknown command
        rq0 = req_cnt; oe0 = oe_cnt;
        do_read(8'h9F, 24'($urandom), 0, 2);
        check("ignore_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) check("ignore_miso", 32'(rxq[i]), 32'hFF);
        cs_high();
        check("ignore_no_oe", 32'(oe_cnt - oe0), 32'd0);
        check("ignore_no_req", 32'(req_cnt - rq0), 32'd0);
        check("ignore_idle", 32'(busy), 32'd0);

        // Fast read
        mem[24'h000020] = 8'($urandom);
        rq0 = req_cnt; oe0 = oe_cnt;
        do_read(8'h0B, 24'h000020, 1, 1);
        cs_high();
`ifdef SPI_FAST_READ_EN
        check_read("fast", 24'h000020, 1);
`else
        check("fast_off_miso", 32'(rxq[0]), 32'hFF);
        check("fast_off_no_req", 32'(req_cnt - rq0), 32'd0);
        check("fast_off_no_oe", 32'(oe_cnt - oe0), 32'd0);
`endif

        // Randomized reads
        for (int k = 0; k < 4; k++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            ack_dly = $urandom_range(0, 3);
            for (int i = 0; i <= n; i++) mem[a + 24'(i)] = 8'($urandom);
            do_read(8'h03, a, 0, n);
            cs_high();
            check_read("rand", a, n);
        end
        check("rand_underrun", 32'(underrun), 32'd0);

        // Underrun: memory never acknowledges
        ack_en = 1'b0;
        a = 24'($urandom);
        do_read(8'h03, a, 0, 1);
        check("underrun_data", 32'(rxq[0]), 32'hFF);
        check("underrun_flag", 32'(underrun), 32'd1);
        cs_high();
        check("underrun_sticky", 32'(underrun), 32'd1);
        check("underrun_addr", 32'(mem_addr), 32'(a + 24'd2));
        check("underrun_req_drop", 32'(mem_req), 32'd0);
        ack_en = 1'b1;
        do_reset();
        check("underrun_cleared", 32'(underrun), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
